sliding_window_gen: RTL and testbench

//  Parametrised K x K sliding-window pixel sequencer for the DNN image path.
//  - Walks every window origin of an IMG_W x IMG_H image held in a synchronous RAM, with configurable STRIDE.
//  - For each window, issues the K*K pixel addresses and returns the read data as a valid/ready pixel stream.
//  - Tags each pixel with its window index, last-in-window and last-in-frame.
//  - Adds start/busy/done control and consumer backpressure, absorbed by a small output FIFO.

---
 rtl/sliding_window_if.sv | 30 +++
 rtl/sliding_window_gen.sv | 176 +++++++++++++++++
 tb/tb_sliding_window_gen.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sliding_window_if.sv
// RAM read port and pixel stream of the sliding-window sequencer.
// master = sequencer side, slave = RAM model / pixel consumer side.
interface sliding_window_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] pix_data;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_valid;
  logic              pix_ready;
  logic              win_last;
  logic              frame_last;

  modport master (
    output ram_addr,
    input  ram_q,
    output pix_data, pix_idx, pix_valid, win_last, frame_last,
    input  pix_ready
  );

  modport slave (
    input  ram_addr,
    output ram_q,
    input  pix_data, pix_idx, pix_valid, win_last, frame_last,
    output pix_ready
  );
endinterface

// File: rtl/sliding_window_gen.sv
// K x K sliding-window pixel sequencer: walks window origins over an image in RAM
// and streams each window's pixels with tags through a credit-guarded FWFT FIFO.
module sliding_window_gen #(
  parameter int IMG_W   = 100,
  parameter int IMG_H   = 121,
  parameter int K       = 15,
  parameter int STRIDE  = 1,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1,
  parameter int IDX_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  sliding_window_if.master        bus
);

  localparam int NX     = (IMG_W - K) / STRIDE + 1;
  localparam int NY     = (IMG_H - K) / STRIDE + 1;
  localparam int XW     = $clog2(IMG_W + 1);
  localparam int YW     = $clog2(IMG_H + 1);
  localparam int D      = RAM_LAT + 2;
  localparam int PW     = $clog2(D);
  localparam int CW     = $clog2(2 * D + 1);

  localparam logic [XW-1:0] KX_MAX  = XW'(K - 1);
  localparam logic [XW-1:0] OX_LAST = XW'((NX - 1) * STRIDE);
  localparam logic [XW-1:0] STEP_X  = XW'(STRIDE);
  localparam logic [YW-1:0] KY_MAX  = YW'(K - 1);
  localparam logic [YW-1:0] OY_LAST = YW'((NY - 1) * STRIDE);
  localparam logic [YW-1:0] STEP_Y  = YW'(STRIDE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             win_last;
    logic             frame_last;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    tag_t              tag;
  } pix_t;

  state_t            state, state_nxt;
  logic [XW-1:0]     ox, kx;
  logic [YW-1:0]     oy, ky;
  logic [IDX_W-1:0]  idx;
  logic              last_kx, last_ky, win_end, frame_end;
  logic              start_frame, issue, push, pop;

  tag_t              tag_q [RAM_LAT];
  logic [RAM_LAT-1:0] tag_vld;
  pix_t              cap_q;
  logic              cap_vld;
  logic [CW-1:0]     inflight;

  pix_t              mem [D];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  pix_t              head;
  logic              done_q;

  assign last_kx     = (kx == KX_MAX);
  assign last_ky     = (ky == KY_MAX);
  assign win_end     = last_kx && last_ky;
  assign frame_end   = win_end && (ox == OX_LAST) && (oy == OY_LAST);
  assign start_frame = (state == IDLE) && start;
  assign push        = cap_vld;
  assign pop         = (count != '0) && bus.pix_ready;
  assign head        = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so crediting it keeps the stream bubble-free.
  assign issue = (state == RUN) && ((count + inflight) < (CW'(D) + CW'(pop)));

  always_comb begin
    inflight = CW'(cap_vld);
    for (int i = 0; i < RAM_LAT; i++) inflight = inflight + CW'(tag_vld[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the block leaves a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)                  state_nxt = RUN;
      RUN:     if (issue && frame_end)     state_nxt = DRAIN;
      DRAIN:   if (pop && head.tag.frame_last) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    done           = done_q;
    bus.pix_valid  = (count != '0);
    bus.pix_data   = bus.pix_valid ? head.data           : '0;
    bus.pix_idx    = bus.pix_valid ? head.tag.idx        : '0;
    bus.win_last   = bus.pix_valid && head.tag.win_last;
    bus.frame_last = bus.pix_valid && head.tag.frame_last;
  end

  always_comb begin
    bus.ram_addr = ADDR_W'((32'(oy) + 32'(ky)) * 32'(IMG_W) + 32'(ox) + 32'(kx));
  end

  // Counters freeze on the final issue so ram_addr holds the last address while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox <= '0; oy <= '0; kx <= '0; ky <= '0; idx <= '0;
    end else if (start_frame) begin
      ox <= '0; oy <= '0; kx <= '0; ky <= '0; idx <= '0;
    end else if (issue && !frame_end) begin
      idx <= win_end ? '0 : idx + IDX_W'(1);
      if (!last_kx) begin
        kx <= kx + XW'(1);
      end else begin
        kx <= '0;
        if (!last_ky) begin
          ky <= ky + YW'(1);
        end else begin
          ky <= '0;
          if (ox != OX_LAST) begin
            ox <= ox + STEP_X;
          end else begin
            ox <= '0;
            oy <= oy + STEP_Y;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      cap_vld <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      done_q  <= 1'b0;
    end else begin
      tag_vld[0] <= issue;
      for (int i = 1; i < RAM_LAT; i++) tag_vld[i] <= tag_vld[i-1];
      cap_vld <= tag_vld[RAM_LAT-1];
      if (push) wr_ptr <= (wr_ptr == PW'(D - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(D - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      done_q <= pop && head.tag.frame_last;
    end
  end

  // NOTE: payload storage has no reset; validity comes only from the reset-cleared
  // valid bits and FIFO count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    tag_q[0] <= '{idx: idx, win_last: win_end, frame_last: frame_end};
    for (int i = 1; i < RAM_LAT; i++) tag_q[i] <= tag_q[i-1];
    cap_q <= '{data: bus.ram_q, tag: tag_q[RAM_LAT-1]};
    if (push) mem[wr_ptr] <= cap_q;
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: table of frame runs (stride, ready pattern) scored
// against a geometry model queue, plus hand sequences for reset and start-while-busy.
module tb_sliding_window_gen;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 6;
  localparam int K       = 3;
  localparam int RAM_LAT = 1;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
    logic       wl;
    logic       fl;
  } pix_t;

  typedef struct {
    int stride2;
    int mode;
    int busy_pulse;
    int exp_xfers;
    int exp_wins;
    int exp_last_win;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0;
  logic busy1, done1, busy2, done2;

  sliding_window_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) b1 ();
  sliding_window_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) b2 ();

  sliding_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(1), .ADDR_W(ADDR_W),
                       .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .IDX_W(IDX_W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(b1));

  sliding_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(2), .ADDR_W(ADDR_W),
                       .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .IDX_W(IDX_W)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(b2));

  always #5 clk = ~clk;

  // RAM model: one-cycle latency, content equals the low address byte.
  always @(posedge clk) b1.ram_q <= b1.ram_addr[7:0];
  always @(posedge clk) b2.ram_q <= b2.ram_addr[7:0];

  int   total = 0, bad = 0;
  pix_t exp_q[$];
  int   sel = 0, ready_mode = 0;
  int   xfers, wins, last_win, dones, bubbles, low_cnt = 0;
  bit   seen_first, did_long;
  bit   stall1 = 0, stall2 = 0;
  pix_t prev1, prev2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input int s);
    pix_t p;
    for (int oy = 0; oy <= IMG_H - K; oy += s)
      for (int ox = 0; ox <= IMG_W - K; ox += s)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            p.data = 8'((oy + ky) * IMG_W + ox + kx);
            p.idx  = 4'(ky * K + kx);
            p.wl   = (ky == K - 1) && (kx == K - 1);
            p.fl   = 1'b0;
            exp_q.push_back(p);
          end
    exp_q[exp_q.size() - 1].fl = 1'b1;
  endfunction

  task automatic on_xfer(input pix_t a);
    pix_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL pix_unexpected: got %0h expected none at %0t", a, $time);
    end else begin
      e = exp_q.pop_front();
      check("pixel", 32'(a), 32'(e));
      xfers++;
      if (a.wl) wins++;
      if (a.idx == 4'd0) last_win = int'(a.data);
    end
  endtask

  always @(negedge clk) begin
    pix_t a;
    if (rst) begin
      stall1 = 1'b0;
    end else begin
      a = {b1.pix_data, b1.pix_idx, b1.win_last, b1.frame_last};
      if (stall1) check("stall_hold1", {b1.pix_valid, a}, {1'b1, prev1});
      if (b1.pix_valid && b1.pix_ready) on_xfer(a);
      stall1 = b1.pix_valid && !b1.pix_ready;
      prev1  = a;
      if (done1) dones++;
      if (sel == 0) begin
        if (b1.pix_valid) seen_first = 1'b1;
        else if (seen_first && busy1) bubbles++;
      end
    end
  end

  always @(negedge clk) begin
    pix_t a;
    if (rst) begin
      stall2 = 1'b0;
    end else begin
      a = {b2.pix_data, b2.pix_idx, b2.win_last, b2.frame_last};
      if (stall2) check("stall_hold2", {b2.pix_valid, a}, {1'b1, prev2});
      if (b2.pix_valid && b2.pix_ready) on_xfer(a);
      stall2 = b2.pix_valid && !b2.pix_ready;
      prev2  = a;
      if (done2) dones++;
      if (sel == 1) begin
        if (b2.pix_valid) seen_first = 1'b1;
        else if (seen_first && busy2) bubbles++;
      end
    end
  end

  // Consumer: always ready, or random with one 10-cycle stall mid-window.
  initial begin
    logic r;
    b1.pix_ready = 1'b0;
    b2.pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (low_cnt > 0) begin
        low_cnt--;
        r = 1'b0;
      end else if (ready_mode == 0) begin
        r = 1'b1;
      end else if (!did_long && xfers >= 40) begin
        did_long = 1'b1;
        low_cnt  = 9;
        r = 1'b0;
      end else begin
        r = 1'($urandom_range(0, 1));
      end
      b1.pix_ready = r;
      b2.pix_ready = r;
    end
  end

  task automatic clear_stats();
    xfers = 0; wins = 0; last_win = -1; dones = 0; bubbles = 0;
    seen_first = 1'b0; did_long = 1'b0;
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) start2 = v;
    else          start1 = v;
  endtask

  task automatic run_frame(input vec_t v);
    int   lat, n;
    logic bz, vl, dn;
    sel        = v.stride2;
    ready_mode = v.mode;
    clear_stats();
    push_frame(v.stride2 != 0 ? 2 : 1);
    @(posedge clk); #1;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    bz = (sel == 1) ? busy2 : busy1;
    check("busy_after_start", 32'(bz), 32'd1);
    lat = 0;
    vl  = (sel == 1) ? b2.pix_valid : b1.pix_valid;
    while (!vl && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      vl = (sel == 1) ? b2.pix_valid : b1.pix_valid;
    end
    check("valid_latency", 32'(lat), 32'd3);
    if (v.busy_pulse != 0) begin
      repeat (20) @(posedge clk);
      #1 set_start(1'b1);
      repeat (5) @(posedge clk);
      #1 set_start(1'b0);
    end
    n  = 0;
    dn = (sel == 1) ? done2 : done1;
    while (!dn && n < 5000) begin
      @(posedge clk); #1;
      n++;
      dn = (sel == 1) ? done2 : done1;
    end
    check("done_seen", 32'(n < 5000), 32'd1);
    bz = (sel == 1) ? busy2 : busy1;
    check("busy_at_done", 32'(bz), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    bz = (sel == 1) ? busy2 : busy1;
    check("idle_after_frame", 32'(bz), 32'd0);
    check("transfers", 32'(xfers), 32'(v.exp_xfers));
    check("windows", 32'(wins), 32'(v.exp_wins));
    check("last_win_addr", 32'(last_win), 32'(v.exp_last_win));
    check("done_pulses", 32'(dones), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    if (v.mode == 0) check("bubbles", 32'(bubbles), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int   n;
    vecs[0] = '{stride2: 0, mode: 0, busy_pulse: 0, exp_xfers: 216, exp_wins: 24, exp_last_win: 29};
    vecs[1] = '{stride2: 0, mode: 1, busy_pulse: 0, exp_xfers: 216, exp_wins: 24, exp_last_win: 29};
    vecs[2] = '{stride2: 1, mode: 0, busy_pulse: 0, exp_xfers: 54,  exp_wins: 6,  exp_last_win: 20};
    vecs[3] = '{stride2: 1, mode: 1, busy_pulse: 0, exp_xfers: 54,  exp_wins: 6,  exp_last_win: 20};
    vecs[4] = '{stride2: 0, mode: 0, busy_pulse: 1, exp_xfers: 216, exp_wins: 24, exp_last_win: 29};

    repeat (3) @(posedge clk);
    #1;
    check("por_busy",  32'(busy1), 32'd0);
    check("por_done",  32'(done1), 32'd0);
    check("por_valid", 32'(b1.pix_valid), 32'd0);
    check("por_addr",  32'(b1.ram_addr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Async reset mid-frame at transfer 100, then a clean restart.
    sel        = 0;
    ready_mode = 0;
    clear_stats();
    push_frame(1);
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (xfers < 100 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("reach_xfer_100", 32'(n < 1000), 32'd1);
    check("busy_before_rst", 32'(busy1), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rst_busy",  32'(busy1), 32'd0);
    check("rst_done",  32'(done1), 32'd0);
    check("rst_valid", 32'(b1.pix_valid), 32'd0);
    check("rst_addr",  32'(b1.ram_addr), 32'd0);
    check("rst_pix",   32'({b1.pix_data, b1.pix_idx, b1.win_last, b1.frame_last}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
